// File: rtl/background_index_fetch.sv
// Background index fetch: nearest-neighbour DDA scaling of the VGA scan onto the
// background index ROM, with a 2-cycle aligned palette index output stream.
module background_index_fetch #(
    parameter int SRC_W = 480,
    parameter int SRC_H = 320,
    parameter int DST_W = 640,
    parameter int DST_H = 480,
    parameter int AW    = 18
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          frame_start,
    input  logic          line_start,
    input  logic          pixel_valid,
    output logic [AW-1:0] rom_addr,
    input  logic [4:0]    rom_data,
    output logic [4:0]    index,
    output logic          index_valid
);

    localparam int XW  = $clog2(SRC_W);
    localparam int YW  = $clog2(SRC_H);
    localparam int AXW = $clog2(DST_W + SRC_W);
    localparam int AYW = $clog2(DST_H + SRC_H);

    localparam logic [XW-1:0]  X_LAST     = XW'(SRC_W - 1);
    localparam logic [YW-1:0]  Y_LAST     = YW'(SRC_H - 1);
    localparam logic [XW-1:0]  X_ONE      = XW'(1);
    localparam logic [YW-1:0]  Y_ONE      = YW'(1);
    localparam logic [AXW-1:0] ACC_X_INC  = AXW'(SRC_W);
    localparam logic [AXW-1:0] ACC_X_WRAP = AXW'(DST_W);
    localparam logic [AYW-1:0] ACC_Y_INC  = AYW'(SRC_H);
    localparam logic [AYW-1:0] ACC_Y_WRAP = AYW'(DST_H);
    localparam logic [AW-1:0]  LINE_STEP  = AW'(SRC_W);

    logic [XW-1:0]  src_x_q, src_x_d;
    logic [AXW-1:0] acc_x_q, acc_x_d;
    logic [YW-1:0]  src_y_q, src_y_d;
    logic [AYW-1:0] acc_y_q, acc_y_d;
    logic [AW-1:0]  line_base_q, line_base_d;
    logic           first_line_q, first_line_d;
    logic           pipe_valid_q, pipe_valid_d;
    logic           index_valid_q, index_valid_d;
    logic [4:0]     index_q, index_d;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through this block
        // leaves a variable unassigned, which would otherwise infer a latch.
        src_x_d       = src_x_q;
        acc_x_d       = acc_x_q;
        src_y_d       = src_y_q;
        acc_y_d       = acc_y_q;
        line_base_d   = line_base_q;
        first_line_d  = first_line_q;

        if (frame_start) begin
            src_y_d      = '0;
            acc_y_d      = '0;
            line_base_d  = '0;
            first_line_d = 1'b1;
            src_x_d      = '0;
            acc_x_d      = '0;
        end

        if (line_start) begin
            src_x_d = '0;
            acc_x_d = '0;
            if (first_line_d) begin
                first_line_d = 1'b0;
            end else begin
                acc_y_d = acc_y_d + ACC_Y_INC;
                if (acc_y_d >= ACC_Y_WRAP) begin
                    acc_y_d = acc_y_d - ACC_Y_WRAP;
                    if (src_y_d != Y_LAST) begin
                        src_y_d     = src_y_d + Y_ONE;
                        line_base_d = line_base_d + LINE_STEP;
                    end
                end
            end
        end

        // The address reflects any frame/line restart of this same cycle, so a
        // pixel coinciding with line_start fetches column 0 of the new line.
        rom_addr = line_base_d + AW'(src_x_d);

        if (pixel_valid) begin
            acc_x_d = acc_x_d + ACC_X_INC;
            if (acc_x_d >= ACC_X_WRAP) begin
                acc_x_d = acc_x_d - ACC_X_WRAP;
                if (src_x_d != X_LAST) begin
                    src_x_d = src_x_d + X_ONE;
                end
            end
        end

        pipe_valid_d  = pixel_valid;
        index_valid_d = pipe_valid_q;
        index_d       = pipe_valid_q ? rom_data : index_q;
    end

    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignments here so every flop samples the values
        // from before the edge, independent of statement order.
        if (Reset) begin
            src_x_q       <= '0;
            acc_x_q       <= '0;
            src_y_q       <= '0;
            acc_y_q       <= '0;
            line_base_q   <= '0;
            first_line_q  <= 1'b1;
            pipe_valid_q  <= 1'b0;
            index_valid_q <= 1'b0;
            index_q       <= '0;
        end else begin
            src_x_q       <= src_x_d;
            acc_x_q       <= acc_x_d;
            src_y_q       <= src_y_d;
            acc_y_q       <= acc_y_d;
            line_base_q   <= line_base_d;
            first_line_q  <= first_line_d;
            pipe_valid_q  <= pipe_valid_d;
            index_valid_q <= index_valid_d;
            index_q       <= index_d;
        end
    end

    assign index       = index_q;
    assign index_valid = index_valid_q;

endmodule

// File: tb/tb_background_index_fetch.sv
// Self-checking bench for background_index_fetch: vector table, directed corner
// sequences and randomized scan traffic against a pixel/line-count reference.
module tb_background_index_fetch;

    localparam int SRC_W = 480;
    localparam int SRC_H = 320;
    localparam int DST_W = 640;
    localparam int DST_H = 480;
    localparam int AW    = 18;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          frame_start = 1'b0;
    logic          line_start = 1'b0;
    logic          pixel_valid = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [4:0]    rom_data;
    logic [4:0]    index;
    logic          index_valid;

    background_index_fetch #(
        .SRC_W(SRC_W), .SRC_H(SRC_H), .DST_W(DST_W), .DST_H(DST_H), .AW(AW)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_start(frame_start),
        .line_start (line_start),
        .pixel_valid(pixel_valid),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .index      (index),
        .index_valid(index_valid)
    );

    always #5 Clk = ~Clk;

    // Synchronous ROM whose content is the low 5 address bits.
    always_ff @(posedge Clk) rom_data <= rom_addr[4:0];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference: position is tracked as pixels-into-line and lines-into-frame;
    // the source coordinate follows directly from the scale ratio.
    int          m_p, m_l;
    bit          m_first;
    bit          m_d1_v;
    int          m_d1_a;
    bit          m_out_v;
    int          m_out_idx;
    bit          m_known = 1'b0;
    logic [31:0] last_addr;

    function automatic int exp_addr_of(input int l, input int p);
        int sy, sx;
        sy = (l * SRC_H) / DST_H;
        if (sy > SRC_H - 1) sy = SRC_H - 1;
        sx = (p * SRC_W) / DST_W;
        if (sx > SRC_W - 1) sx = SRC_W - 1;
        return sy * SRC_W + sx;
    endfunction

    task automatic cyc(input bit rst, input bit fs, input bit ls, input bit pv);
        int ea;
        @(negedge Clk);
        Reset       = rst;
        frame_start = fs;
        line_start  = ls;
        pixel_valid = pv;
        #1;
        if (m_known) begin
            check("index_valid", 32'(index_valid), 32'(m_out_v));
            check("index", 32'(index), m_out_idx);
        end
        last_addr = 32'(rom_addr);
        if (rst) begin
            m_p = 0; m_l = 0; m_first = 1'b1;
            m_d1_v = 1'b0; m_out_v = 1'b0; m_out_idx = 0;
            m_known = 1'b1;
        end else begin
            if (fs) begin m_l = 0; m_first = 1'b1; m_p = 0; end
            if (ls) begin
                m_p = 0;
                if (m_first) m_first = 1'b0;
                else m_l++;
            end
            ea = exp_addr_of(m_l, m_p);
            check("rom_addr", last_addr, ea);
            m_out_v = m_d1_v;
            if (m_d1_v) m_out_idx = m_d1_a % 32;
            m_d1_v = pv;
            m_d1_a = ea;
            if (pv) m_p++;
        end
    endtask

    typedef struct {
        bit rst;
        bit fs;
        bit ls;
        bit pv;
        int exp_addr;   // -1: no table expectation for this step
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, -1};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0,  0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1,  0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1,  0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1,  1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1,  2};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1,  3};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1,  3};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1,  4};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1,  5};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0,  6};

        // Reset state and first pixels of line 0.
        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].rst, tbl[i].fs, tbl[i].ls, tbl[i].pv);
            if (tbl[i].exp_addr >= 0) check("tbl_addr", last_addr, tbl[i].exp_addr);
        end

        // Rest of the 640-pixel line; last pixel lands on column 479.
        for (int i = 8; i < DST_W; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("line_last_addr", last_addr, 479);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("last_index_valid", 32'(index_valid), 1);
        check("last_index", 32'(index), 479 % 32);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("index_valid_drop", 32'(index_valid), 0);
        check("index_hold", 32'(index), 479 % 32);

        // Lines 1..3 base addresses.
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        check("line1_base", last_addr, 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        check("line2_base", last_addr, 480);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        check("line3_base", last_addr, 960);

        // Gapped pixels keep index alignment.
        for (int i = 0; i < 60; i++) cyc(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));

        // Overlong line: columns saturate at 479.
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 700; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
            if (i >= 640) check("xsat_addr", last_addr, 960 + 479);
        end

        // Remaining lines past the bottom: rows saturate at line 319.
        for (int l = 5; l <= 490; l++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
            for (int i = 0; i < ((l == 479) ? DST_W : 2); i++) begin
                if ($urandom_range(0, 3) == 0) cyc(1'b0, 1'b0, 1'b0, 1'b0);
                cyc(1'b0, 1'b0, 1'b0, 1'b1);
            end
            if (l == 479) check("line479_last_addr", last_addr, 153599);
        end
        check("ysat_addr", last_addr, 153120);

        // frame_start + line_start + pixel in one cycle; next line still row 0.
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        check("fs_ls_addr", last_addr, 0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        check("after_fs_ls_line", last_addr, 0);

        // Reset mid-line with pixels in flight.
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_index_valid", 32'(index_valid), 0);
        check("rst_index", 32'(index), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_index_valid2", 32'(index_valid), 0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        check("restart_addr", last_addr, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("restart_addr2", last_addr, 0);

        // Randomized scan traffic.
        for (int i = 0; i < 5000; i++) begin
            cyc(1'($urandom_range(0, 499) == 0),
                1'($urandom_range(0, 299) == 0),
                1'($urandom_range(0, 39) == 0),
                1'($urandom_range(0, 9) < 7));
        end
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
